alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-issue controller sequencing register reads, an external ALU and writeback
module alu_issue_ctrl #(
    parameter logic [4:0] RESET_FLAGS = 5'b00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_flags,
    input  logic [15:0] alu_result,
    input  logic [4:0]  alu_flags_in,
    output logic        done,
    output logic [4:0]  flags,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] regs [16];
    logic [15:0] ir;
    logic [15:0] res_q;
    logic [4:0]  cflags_q;

    logic [3:0]  ir_op;
    logic [3:0]  ir_rd;
    logic [3:0]  ir_rs;
    logic        ir_imm_sel;
    logic [15:0] ir_imm;
    logic        wr_en;

    assign ir_op      = ir[15:12];
    assign ir_rd      = ir[11:8];
    assign ir_rs      = ir[3:0];
    assign ir_imm_sel = ir[7];
    assign ir_imm     = {{9{ir[6]}}, ir[6:0]};

    // Compares and NOP only update flags; every other code writes back.
    assign wr_en = (ir_op != 4'b1011) && (ir_op != 4'b1000) && (ir_op != 4'b0000);

    assign alu_flags = flags;
    assign dbg_data  = regs[dbg_addr];

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nxt = READ;
            end
            READ: state_nxt = EXEC;
            EXEC: state_nxt = WB;
            WB: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ir       <= 16'h0000;
            alu_op   <= 4'h0;
            alu_a    <= 16'h0000;
            alu_b    <= 16'h0000;
            res_q    <= 16'h0000;
            cflags_q <= 5'b00000;
            flags    <= RESET_FLAGS;
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (instr_valid) ir <= instr;
                end
                READ: begin
                    // Both operands come from the pre-instruction file, so rd==rs is safe.
                    alu_a  <= regs[ir_rd];
                    alu_b  <= ir_imm_sel ? ir_imm : regs[ir_rs];
                    alu_op <= ir_op;
                end
                EXEC: begin
                    res_q    <= alu_result;
                    cflags_q <= alu_flags_in;
                end
                WB: begin
                    if (wr_en) regs[ir_rd] <= res_q;
                    flags  <= cflags_q;
                    alu_op <= 4'h0;
                end
                default: ;
            endcase
        end
    end

endmodule
